aes256_cbc_framer: RTL
======================

# aes256_cbc_framer

Builds the AXI-Stream command stream consumed by the AES-256-CBC iterative core from a per-message configuration and a raw data stream. For each message it emits the low key half, the high key half, the IV, and then the data blocks. In encrypt mode it applies PKCS#7 padding. It sits directly upstream of the CBC core's slave port, and its master port connects straight to that core.

## Interface
- No parameters. Widths come from `AES_BLOCK_SIZE` (128) and `AES256_KEY_LENGTH` (256) in `aes_defines.svh`.
- Clk  in  1  single clock; all logic on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Cfg_valid  in  1  configuration handshake valid.
- Cfg_ready  out  1  high when state is IDLE and the output register is free.
- Cfg_key  in  256  AES-256 key, sampled on Cfg handshake.
- Cfg_iv  in  128  IV, sampled on Cfg handshake.
- Cfg_encrypt  in  1  1 = encrypt, 0 = decrypt; sampled on Cfg handshake.
- S_axis_tvalid / S_axis_tready  in / out  1  data-in handshake.
- S_axis_tdata  in  128  byte i at bits [8i+7:8i].
- S_axis_tkeep  in  16  byte-valid mask, expected contiguous from bit 0.
- S_axis_tlast  in  1  last beat of the message.
- M_axis_tvalid / M_axis_tready  out / in  1  command-stream handshake toward the core.
- M_axis_tdata  out  128  key, IV or data block.
- M_axis_tkeep  out  16  always 16'hFFFF while valid, 0 otherwise.
- M_axis_tlast  out  1  set only on the final data/pad block.
- M_axis_tuser  out  1  latched Cfg_encrypt, driven on every beat of the message.
- Err  out  1  sticky framing error; cleared on the next Cfg handshake.

## Operation
- The output side is a single registered stage (data, tlast, tuser, tvalid).
  - The register is "free" when `!M_axis_tvalid | M_axis_tready`.
  - The register loads only when free.
- States: IDLE, KEY_HI, IV, DATA, PAD.
- IDLE:
  - On Cfg handshake, latch key, IV and encrypt; clear Err.
  - Load `Cfg_key[127:0]` with tlast=0, then go to KEY_HI.
- KEY_HI: when free, load `key[255:128]` and go to IV.
- IV: when free, load the IV and go to DATA.
- DATA: `S_axis_tready` = (state==DATA) & free. On each S handshake, load one beat. Define k = length of the contiguous run of ones from tkeep bit 0 (0..16).
  - Non-last beat: output tdata with invalid bytes zeroed. If k≠16, set Err.
  - Last beat, encrypt, k<16: bytes k..15 are replaced by the value (16−k); output tlast=1; go to IDLE. k=0 yields a full block of 0x10.
  - Last beat, encrypt, k=16: output data with tlast=0, then go to PAD.
  - Last beat, decrypt: output data with tlast=1; go to IDLE. If k≠16, set Err (missing bytes are zeroed).
  - Non-contiguous tkeep (a one above the first zero) on any beat sets Err. Only the first k bytes are used.
- PAD: when free, load 16×0x10 with tlast=1 and go to IDLE.
- A new message may start only after the previous final beat has left the output register. This is enforced by Cfg_ready.
- No beats are lost or duplicated under any pattern of M_axis_tready.

## Timing
- Reset values:
  - State IDLE.
  - M_axis_tvalid, tdata, tlast and tuser are 0.
  - M_axis_tkeep is 0; S_axis_tready is 0; Err is 0.
  - Cfg_ready is 1 after reset is released.
- Reset mid-message immediately drops M_axis_tvalid and returns to IDLE. The partial message is discarded; the downstream core must be reset in the same domain.
- Latency:
  - First key beat is valid the cycle after the Cfg handshake.
  - With tready held high, KEY_HI and IV follow on consecutive cycles.
  - Each data beat appears the cycle after its S handshake.
- Throughput: 1 beat/cycle sustained when the sink is always ready. The core itself stalls the stream between blocks.
- A simultaneous M handshake and new load in the same cycle is legal: the register is replaced with no bubble.

## Structure
- Shared package `aes_pkg` (alongside `aes_defines.svh`):
  - state enum `framer_state_t`;
  - constant `AES_PKCS7_FULL_PAD = {16{8'h10}}`.
- One combinational sub-module, `aes_pkcs7_pad`:
  - inputs: data[127:0], keep[15:0], pad_enable;
  - outputs: padded data, k[4:0], contiguity error.
- The FSM, output register and Err flag live in `aes256_cbc_framer`.

## Test plan
- Encrypt, 32-byte message (2 full beats), key `000102..1F`, IV `0F0E..00` → 6 beats:
  - key[127:0], key[255:128], IV, d0, d1, then 16×0x10 with tlast;
  - tuser=1 on all beats; Err=0.
- Encrypt, 21-byte message (last tkeep=16'h001F) → second data beat has bytes 5..15 = 0x0B with tlast=1; no PAD beat.
- Decrypt, 2 full blocks → 5 beats, tuser=0, tlast on the 5th, no padding.
- Random M_axis_tready (~50% duty) over 50 messages of random length → output beat sequence matches the reference model exactly.
- Non-last beat with tkeep=16'h00FF → Err=1 and stays set until the next Cfg handshake, then reads 0.
- Assert Rst while in DATA with M_axis_tvalid=1 → tvalid=0 in the same cycle; after release, Cfg_ready=1 and a fresh message frames correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: block/key widths, framer state encoding and the
// full PKCS#7 pad block.
package aes_pkg;

  localparam int AES_BLOCK_SIZE    = 128;
  localparam int AES256_KEY_LENGTH = 256;
  localparam int AES_BLOCK_BYTES   = AES_BLOCK_SIZE / 8;

  localparam logic [AES_BLOCK_SIZE-1:0] AES_PKCS7_FULL_PAD = {16{8'h10}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_HI,
    ST_IV,
    ST_DATA,
    ST_PAD
  } framer_state_t;

endpackage

// File: rtl/aes_pkcs7_pad.sv
// Combinational beat conditioner: measures the valid-byte run from tkeep bit 0,
// flags holes in tkeep, and zeroes or PKCS#7-pads the bytes beyond the run.
module aes_pkcs7_pad
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_SIZE-1:0]  data,
  input  logic [AES_BLOCK_BYTES-1:0] keep,
  input  logic                       pad_enable,
  output logic [AES_BLOCK_SIZE-1:0]  padded,
  output logic [4:0]                 k,
  output logic                       contig_err
);

  logic       run;
  logic [7:0] pad_byte;

  always_comb begin
    k          = '0;
    contig_err = 1'b0;
    run        = 1'b1;
    for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
      if (run && keep[i]) begin
        k = k + 5'd1;
      end else begin
        // a set bit after the first clear bit is a hole in the mask
        if (keep[i]) contig_err = 1'b1;
        run = 1'b0;
      end
    end
  end

  assign pad_byte = 8'd16 - {3'b000, k};

  always_comb begin
    padded = '0;
    for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
      if (5'(i) < k)       padded[8*i +: 8] = data[8*i +: 8];
      else if (pad_enable) padded[8*i +: 8] = pad_byte;
      else                 padded[8*i +: 8] = 8'h00;
    end
  end

endmodule

// File: rtl/aes256_cbc_framer.sv
// Frames key halves, IV and (padded) data into the CBC core command stream
// through a single registered output stage.
//   state  | meaning
//   IDLE   | waiting for a Cfg handshake; low key half loads on accept
//   KEY_HI | high key half pending load
//   IV     | IV pending load
//   DATA   | forwarding data beats from S_axis
//   PAD    | full 16x0x10 pad block pending load
module aes256_cbc_framer
  import aes_pkg::*;
(
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Cfg_valid,
  output logic                         Cfg_ready,
  input  logic [AES256_KEY_LENGTH-1:0] Cfg_key,
  input  logic [AES_BLOCK_SIZE-1:0]    Cfg_iv,
  input  logic                         Cfg_encrypt,
  input  logic                         S_axis_tvalid,
  output logic                         S_axis_tready,
  input  logic [AES_BLOCK_SIZE-1:0]    S_axis_tdata,
  input  logic [AES_BLOCK_BYTES-1:0]   S_axis_tkeep,
  input  logic                         S_axis_tlast,
  output logic                         M_axis_tvalid,
  input  logic                         M_axis_tready,
  output logic [AES_BLOCK_SIZE-1:0]    M_axis_tdata,
  output logic [AES_BLOCK_BYTES-1:0]   M_axis_tkeep,
  output logic                         M_axis_tlast,
  output logic                         M_axis_tuser,
  output logic                         Err
);

  framer_state_t             state_q, state_d;
  logic [AES_BLOCK_SIZE-1:0] key_hi_q, key_hi_d;
  logic [AES_BLOCK_SIZE-1:0] iv_q, iv_d;
  logic                      enc_q, enc_d;
  logic                      err_q, err_d;
  logic [AES_BLOCK_SIZE-1:0] m_data_q, m_data_d;
  logic                      m_last_q, m_last_d;
  logic                      m_user_q, m_user_d;
  logic                      m_valid_q, m_valid_d;

  logic                      free;
  logic [AES_BLOCK_SIZE-1:0] padded;
  logic [4:0]                k;
  logic                      contig_err;

  aes_pkcs7_pad u_pad (
    .data       (S_axis_tdata),
    .keep       (S_axis_tkeep),
    .pad_enable (enc_q & S_axis_tlast),
    .padded     (padded),
    .k          (k),
    .contig_err (contig_err)
  );

  assign free          = !m_valid_q || M_axis_tready;
  assign Cfg_ready     = (state_q == ST_IDLE) && free;
  assign S_axis_tready = (state_q == ST_DATA) && free;

  always_comb begin
    state_d   = state_q;
    key_hi_d  = key_hi_q;
    iv_d      = iv_q;
    enc_d     = enc_q;
    err_d     = err_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;
    m_valid_d = m_valid_q;

    // an accepted beat drains the register unless something reloads it below
    if (free) m_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Cfg_valid && free) begin
          key_hi_d  = Cfg_key[255:128];
          iv_d      = Cfg_iv;
          enc_d     = Cfg_encrypt;
          err_d     = 1'b0;
          m_data_d  = Cfg_key[127:0];
          m_last_d  = 1'b0;
          m_user_d  = Cfg_encrypt;
          m_valid_d = 1'b1;
          state_d   = ST_KEY_HI;
        end
      end
      ST_KEY_HI: begin
        if (free) begin
          m_data_d  = key_hi_q;
          m_last_d  = 1'b0;
          m_user_d  = enc_q;
          m_valid_d = 1'b1;
          state_d   = ST_IV;
        end
      end
      ST_IV: begin
        if (free) begin
          m_data_d  = iv_q;
          m_last_d  = 1'b0;
          m_user_d  = enc_q;
          m_valid_d = 1'b1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (S_axis_tvalid && free) begin
          m_data_d  = padded;
          m_user_d  = enc_q;
          m_valid_d = 1'b1;
          // short beats are only legal as the final encrypt beat
          if (contig_err || ((k != 5'd16) && (!S_axis_tlast || !enc_q))) err_d = 1'b1;
          if (!S_axis_tlast) begin
            m_last_d = 1'b0;
          end else if (enc_q && (k == 5'd16)) begin
            m_last_d = 1'b0;
            state_d  = ST_PAD;
          end else begin
            m_last_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_PAD: begin
        if (free) begin
          m_data_d  = AES_PKCS7_FULL_PAD;
          m_last_d  = 1'b1;
          m_user_d  = enc_q;
          m_valid_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      key_hi_q  <= '0;
      iv_q      <= '0;
      enc_q     <= 1'b0;
      err_q     <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      m_user_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_hi_q  <= key_hi_d;
      iv_q      <= iv_d;
      enc_q     <= enc_d;
      err_q     <= err_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign M_axis_tvalid = m_valid_q;
  assign M_axis_tdata  = m_data_q;
  assign M_axis_tkeep  = m_valid_q ? 16'hFFFF : 16'h0000;
  assign M_axis_tlast  = m_last_q;
  assign M_axis_tuser  = m_user_q;
  assign Err           = err_q;

endmodule
